// File: rtl/tlul_sram_slave.sv
// TL-UL single-port SRAM slave: one outstanding transaction, byte-masked Puts,
// request error detection and a fixed programmable response latency.
//
// state  | meaning
// IDLE   | ready for a Channel A request
// WAIT   | response captured, counting down the extra latency
// RESP   | Channel D valid, held until d_ready

module tlul_sram_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    localparam int MASK_WIDTH  = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 2,
    parameter int SINK_WIDTH   = 1,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int DEPTH        = 4096,
    parameter int LATENCY      = 0,
    parameter logic [SINK_WIDTH-1:0] SINK_ID = '0
) (
    input  logic                    clk_100,
    input  logic                    reset,
    input  logic                    slave_a_valid,
    output logic                    slave_a_ready,
    input  logic [OPCODE_WIDTH-1:0] slave_a_opcode,
    input  logic [PARAM_WIDTH-1:0]  slave_a_param,
    input  logic [SIZE_WIDTH-1:0]   slave_a_size,
    input  logic [SRC_WIDTH-1:0]    slave_a_source,
    input  logic [ADDR_WIDTH-1:0]   slave_a_address,
    input  logic [MASK_WIDTH-1:0]   slave_a_mask,
    input  logic [DATA_WIDTH-1:0]   slave_a_data,
    output logic                    slave_d_valid,
    input  logic                    slave_d_ready,
    output logic [OPCODE_WIDTH-1:0] slave_d_opcode,
    output logic [PARAM_WIDTH-1:0]  slave_d_param,
    output logic [SIZE_WIDTH-1:0]   slave_d_size,
    output logic [SRC_WIDTH-1:0]    slave_d_source,
    output logic [SINK_WIDTH-1:0]   slave_d_sink,
    output logic [DATA_WIDTH-1:0]   slave_d_data,
    output logic                    slave_d_error
);

    localparam int LANE_LOG  = $clog2(MASK_WIDTH);
    localparam int IDX_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = 4;
    localparam int AW1       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] REGION_BYTES = AW1'(DEPTH * MASK_WIDTH);

    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   accept;
    logic                   is_get, is_put, req_err;
    logic                   in_range, misaligned, size_bad;
    logic [ADDR_WIDTH:0]    offset_ext;
    logic [ADDR_WIDTH-1:0]  align_mask;
    logic [IDX_WIDTH-1:0]   word_idx;

    logic [OPCODE_WIDTH-1:0] rsp_opcode;
    logic [SIZE_WIDTH-1:0]   rsp_size;
    logic [SRC_WIDTH-1:0]    rsp_source;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    rsp_error;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // One extra bit keeps addresses below BASE_ADDR from wrapping into range.
    assign offset_ext = {1'b0, slave_a_address} - {1'b0, BASE_ADDR};
    assign in_range   = (slave_a_address >= BASE_ADDR) && (offset_ext < REGION_BYTES);
    assign align_mask = (ADDR_WIDTH'(1) << slave_a_size) - ADDR_WIDTH'(1);
    assign misaligned = |(slave_a_address & align_mask);
    assign size_bad   = slave_a_size > SIZE_WIDTH'(LANE_LOG);
    assign is_get     = slave_a_opcode == OP_GET;
    assign is_put     = (slave_a_opcode == OP_PUT_FULL) || (slave_a_opcode == OP_PUT_PART);
    assign req_err    = !in_range || !(is_get || is_put) || size_bad || misaligned;
    assign word_idx   = offset_ext[LANE_LOG +: IDX_WIDTH];

    assign slave_a_ready = state_q == S_IDLE;
    assign accept        = slave_a_valid && slave_a_ready;

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_WIDTH'(LATENCY - 1);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_RESP;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            S_RESP: begin
                if (slave_d_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            rsp_opcode <= '0;
            rsp_size   <= '0;
            rsp_source <= '0;
            rsp_data   <= '0;
            rsp_error  <= 1'b0;
        end else if (accept) begin
            rsp_opcode <= is_get ? OP_ACK_DATA : OP_ACK;
            rsp_size   <= slave_a_size;
            rsp_source <= slave_a_source;
            rsp_error  <= req_err;
            rsp_data   <= (is_get && !req_err) ? mem[word_idx] : '0;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk_100) begin
        if (!reset && accept && is_put && !req_err) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (slave_a_mask[b]) mem[word_idx][8*b +: 8] <= slave_a_data[8*b +: 8];
            end
        end
    end

    assign slave_d_valid  = state_q == S_RESP;
    assign slave_d_opcode = rsp_opcode;
    assign slave_d_param  = '0;
    assign slave_d_size   = rsp_size;
    assign slave_d_source = rsp_source;
    assign slave_d_sink   = SINK_ID;
    assign slave_d_data   = rsp_data;
    assign slave_d_error  = rsp_error;

    logic unused_bits;
    assign unused_bits = ^{slave_a_param, offset_ext};

endmodule

// File: tb/tb_tlul_sram_slave.sv
// Bench for tlul_sram_slave: a transaction-level model compared every cycle on a
// zero-latency instance, plus a LATENCY=3 instance for timing and throughput.

module tb_tlul_sram_slave;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_valid, a_ready, d_valid, d_ready, d_error;
    logic [2:0]  a_opcode, a_param, a_size, d_opcode, d_param, d_size;
    logic [1:0]  a_source, d_source;
    logic [31:0] a_address, a_data, d_data;
    logic [3:0]  a_mask;
    logic [0:0]  d_sink;

    logic        b_a_valid, b_a_ready, b_d_valid, b_d_error;
    logic [2:0]  b_a_opcode, b_a_size, b_d_opcode, b_d_param, b_d_size;
    logic [1:0]  b_a_source, b_d_source;
    logic [31:0] b_a_address, b_a_data, b_d_data;
    logic [3:0]  b_a_mask;
    logic [0:0]  b_d_sink;

    initial forever #5 clk = ~clk;

    tlul_sram_slave #(.LATENCY(0)) dut (
        .clk_100(clk), .reset(reset),
        .slave_a_valid(a_valid), .slave_a_ready(a_ready),
        .slave_a_opcode(a_opcode), .slave_a_param(a_param), .slave_a_size(a_size),
        .slave_a_source(a_source), .slave_a_address(a_address), .slave_a_mask(a_mask),
        .slave_a_data(a_data),
        .slave_d_valid(d_valid), .slave_d_ready(d_ready),
        .slave_d_opcode(d_opcode), .slave_d_param(d_param), .slave_d_size(d_size),
        .slave_d_source(d_source), .slave_d_sink(d_sink), .slave_d_data(d_data),
        .slave_d_error(d_error)
    );

    tlul_sram_slave #(.LATENCY(3)) dut_lat (
        .clk_100(clk), .reset(reset),
        .slave_a_valid(b_a_valid), .slave_a_ready(b_a_ready),
        .slave_a_opcode(b_a_opcode), .slave_a_param(3'd0), .slave_a_size(b_a_size),
        .slave_a_source(b_a_source), .slave_a_address(b_a_address), .slave_a_mask(b_a_mask),
        .slave_a_data(b_a_data),
        .slave_d_valid(b_d_valid), .slave_d_ready(1'b1),
        .slave_d_opcode(b_d_opcode), .slave_d_param(b_d_param), .slave_d_size(b_d_size),
        .slave_d_source(b_d_source), .slave_d_sink(b_d_sink), .slave_d_data(b_d_data),
        .slave_d_error(b_d_error)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level model of the zero-latency instance
    localparam int M_DEPTH = 4096;
    localparam int M_LAT   = 0;
    bit [31:0] mm [int];
    bit        mk [int];
    bit        m_busy = 0;
    int        m_wait = 0;
    bit [2:0]  m_op = 0, m_size = 0;
    bit [1:0]  m_src = 0;
    bit        m_err = 0, m_known = 1;
    bit [31:0] m_data = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_busy = 0; m_op = 0; m_size = 0; m_src = 0; m_err = 0; m_data = 0; m_known = 1;
        end else if (m_busy) begin
            if (m_wait == 0) begin
                if (d_ready) m_busy = 0;
            end else begin
                m_wait--;
            end
        end else if (a_valid) begin
            longint off;
            int     idx;
            bit     get, put;
            off = longint'(a_address);
            idx = int'((off / 4) % M_DEPTH);
            get = a_opcode == 3'd4;
            put = a_opcode == 3'd0 || a_opcode == 3'd1;
            m_err = (off >= M_DEPTH * 4) || !(get || put) || (a_size > 3'd2)
                    || ((a_address % (32'd1 << a_size)) != 0);
            m_op   = get ? 3'd1 : 3'd0;
            m_size = a_size;
            m_src  = a_source;
            m_data = 0;
            m_known = 1;
            if (get && !m_err) begin
                m_known = mm.exists(idx) && mk[idx];
                if (m_known) m_data = mm[idx];
            end
            if (put && !m_err) begin
                bit [31:0] w;
                bit        kn;
                w  = mm.exists(idx) ? mm[idx] : 32'h0;
                kn = (a_mask == 4'hF) || (mm.exists(idx) && mk[idx]);
                for (int b = 0; b < 4; b++) if (a_mask[b]) w[8*b +: 8] = a_data[8*b +: 8];
                mm[idx] = w;
                mk[idx] = kn;
            end
            m_busy = 1;
            m_wait = M_LAT;
        end
    end

    always @(negedge clk) begin
        bit exp_dv;
        exp_dv = m_busy && (m_wait == 0);
        check("cmp.a_ready", 32'(a_ready), 32'(!m_busy));
        check("cmp.d_valid", 32'(d_valid), 32'(exp_dv));
        check("cmp.d_sink", 32'(d_sink), 32'd0);
        if (exp_dv) begin
            check("cmp.d_opcode", 32'(d_opcode), 32'(m_op));
            check("cmp.d_param", 32'(d_param), 32'd0);
            check("cmp.d_size", 32'(d_size), 32'(m_size));
            check("cmp.d_source", 32'(d_source), 32'(m_src));
            check("cmp.d_error", 32'(d_error), 32'(m_err));
            if (m_known) check("cmp.d_data", d_data, m_data);
        end
    end

    // ---------------- latency instance monitor (edge = first edge the value is sampled at)
    int        b_ncyc = 0, b_nacc = 0, b_nrise = 0;
    int        b_acc [3];
    int        b_rise [3];
    bit [31:0] b_rdata [3];
    bit        b_prev_dv = 0;

    always @(negedge clk) begin
        b_ncyc++;
        if (b_a_valid && b_a_ready && b_nacc < 3) begin
            b_acc[b_nacc] = b_ncyc + 1;
            b_nacc++;
        end
        if (b_d_valid && !b_prev_dv && b_nrise < 3) begin
            b_rise[b_nrise]  = b_ncyc + 1;
            b_rdata[b_nrise] = b_d_data;
            b_nrise++;
        end
        b_prev_dv = b_d_valid;
    end

    // ---------------- stimulus helpers
    task automatic drive_a(input logic [2:0] op, input logic [2:0] size, input logic [1:0] src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        @(posedge clk); #1;
        a_opcode = op; a_size = size; a_source = src; a_address = addr;
        a_mask = mask; a_data = data; a_param = 3'd5; a_valid = 1'b1;
    endtask

    task automatic wait_accept(input string nm);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_ready) begin ok = 1; break; end
        end
        check({nm, ".accepted"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_resp(input string nm);
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_valid) begin ok = 1; break; end
        end
        check({nm, ".responded"}, 32'(ok), 32'd1);
    endtask

    task automatic txn(input string nm, input logic [2:0] op, input logic [2:0] size,
                       input logic [1:0] src, input logic [31:0] addr, input logic [3:0] mask,
                       input logic [31:0] data, input logic [2:0] e_op, input logic e_err,
                       input logic [31:0] e_data);
        drive_a(op, size, src, addr, mask, data);
        wait_accept(nm);
        wait_resp(nm);
        check({nm, ".opcode"}, 32'(d_opcode), 32'(e_op));
        check({nm, ".error"}, 32'(d_error), 32'(e_err));
        check({nm, ".data"}, d_data, e_data);
        check({nm, ".source"}, 32'(d_source), 32'(src));
        check({nm, ".size"}, 32'(d_size), 32'(size));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; a_valid = 1'b0; d_ready = 1'b1;
        a_opcode = 0; a_param = 0; a_size = 0; a_source = 0; a_address = 0; a_mask = 0; a_data = 0;
        b_a_valid = 1'b0; b_a_opcode = 0; b_a_size = 0; b_a_source = 0;
        b_a_address = 0; b_a_mask = 0; b_a_data = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst.a_ready", 32'(a_ready), 32'd1);
        check("rst.d_valid", 32'(d_valid), 32'd0);
        check("rst.d_opcode", 32'(d_opcode), 32'd0);
        check("rst.d_size", 32'(d_size), 32'd0);
        check("rst.d_source", 32'(d_source), 32'd0);
        check("rst.d_data", d_data, 32'd0);
        check("rst.d_error", 32'(d_error), 32'd0);

        //   name          op    sz    src   addr           mask   data           eop  eerr edata
        txn("put_2000",    3'd0, 3'd2, 2'd1, 32'h0000_2000, 4'hF, 32'hCAFEBABE, 3'd0, 0, 32'h0);
        txn("get_2000",    3'd4, 3'd2, 2'd2, 32'h0000_2000, 4'hF, 32'h0,        3'd1, 0, 32'hCAFEBABE);
        txn("put_3000",    3'd0, 3'd2, 2'd0, 32'h0000_3000, 4'hF, 32'hAAAAAAAA, 3'd0, 0, 32'h0);
        txn("ppart_3000",  3'd1, 3'd2, 2'd3, 32'h0000_3000, 4'h3, 32'h12345678, 3'd0, 0, 32'h0);
        txn("get_3000",    3'd4, 3'd2, 2'd1, 32'h0000_3000, 4'hF, 32'h0,        3'd1, 0, 32'hAAAA5678);
        txn("put_0000",    3'd0, 3'd2, 2'd0, 32'h0000_0000, 4'hF, 32'h01020304, 3'd0, 0, 32'h0);
        txn("put_3ffc",    3'd0, 3'd2, 2'd2, 32'h0000_3FFC, 4'hF, 32'h55AA55AA, 3'd0, 0, 32'h0);
        txn("get_3ffc",    3'd4, 3'd2, 2'd2, 32'h0000_3FFC, 4'hF, 32'h0,        3'd1, 0, 32'h55AA55AA);
        txn("get_oor",     3'd4, 3'd2, 2'd3, 32'h0000_4000, 4'hF, 32'h0,        3'd1, 1, 32'h0);
        txn("put_oor",     3'd0, 3'd2, 2'd3, 32'h0000_4000, 4'hF, 32'hFFFFFFFF, 3'd0, 1, 32'h0);
        txn("bad_opcode",  3'd2, 3'd2, 2'd1, 32'h0000_2000, 4'hF, 32'h0,        3'd0, 1, 32'h0);
        txn("get_misal",   3'd4, 3'd2, 2'd0, 32'h0000_1002, 4'hF, 32'h0,        3'd1, 1, 32'h0);
        txn("put_misal",   3'd0, 3'd2, 2'd0, 32'h0000_2002, 4'hF, 32'h0,        3'd0, 1, 32'h0);
        txn("put_bigsize", 3'd0, 3'd3, 2'd0, 32'h0000_2000, 4'hF, 32'h0,        3'd0, 1, 32'h0);
        txn("get_half",    3'd4, 3'd1, 2'd1, 32'h0000_2002, 4'hF, 32'h0,        3'd1, 0, 32'hCAFEBABE);
        txn("reget_2000",  3'd4, 3'd2, 2'd2, 32'h0000_2000, 4'hF, 32'h0,        3'd1, 0, 32'hCAFEBABE);
        txn("reget_0000",  3'd4, 3'd2, 2'd2, 32'h0000_0000, 4'hF, 32'h0,        3'd1, 0, 32'h01020304);

        // backpressure: D held, second request waits, then goes through
        d_ready = 1'b0;
        drive_a(3'd4, 3'd2, 2'd3, 32'h0000_2000, 4'hF, 32'h0);
        wait_accept("bp1");
        wait_resp("bp1");
        @(posedge clk); #1;
        a_opcode = 3'd4; a_size = 3'd2; a_source = 2'd0; a_address = 32'h0000_3000; a_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.d_valid", 32'(d_valid), 32'd1);
            check("bp.a_ready", 32'(a_ready), 32'd0);
            check("bp.d_data", d_data, 32'hCAFEBABE);
            check("bp.d_source", 32'(d_source), 32'd3);
        end
        @(posedge clk); #1;
        d_ready = 1'b1;
        wait_accept("bp2");
        wait_resp("bp2");
        check("bp2.data", d_data, 32'hAAAA5678);
        check("bp2.source", 32'(d_source), 32'd0);
        @(posedge clk); #1;

        // reset while a Put response is pending
        d_ready = 1'b0;
        drive_a(3'd0, 3'd2, 2'd1, 32'h0000_1000, 4'hF, 32'hDEADBEEF);
        wait_accept("rstmid");
        wait_resp("rstmid");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid.d_valid", 32'(d_valid), 32'd0);
        check("rstmid.a_ready", 32'(a_ready), 32'd1);
        d_ready = 1'b1;
        txn("get_1000", 3'd4, 3'd2, 2'd2, 32'h0000_1000, 4'hF, 32'h0, 3'd1, 0, 32'hDEADBEEF);

        // LATENCY=3 instance: Put then two Gets held valid back to back
        b_a_opcode = 3'd0; b_a_size = 3'd2; b_a_source = 2'd1; b_a_address = 32'h10;
        b_a_mask = 4'hF; b_a_data = 32'h11223344; b_a_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (b_nacc >= 3) begin b_a_valid = 1'b0; break; end
            if (b_nacc >= 1) begin b_a_opcode = 3'd4; b_a_source = 2'd2; end
        end
        b_a_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (b_nrise >= 3) break;
        end
        check("lat.n_accepts", 32'(b_nacc), 32'd3);
        check("lat.n_rises", 32'(b_nrise), 32'd3);
        if (b_nacc == 3 && b_nrise == 3) begin
            check("lat.spacing01", 32'(b_acc[1] - b_acc[0]), 32'd5);
            check("lat.spacing12", 32'(b_acc[2] - b_acc[1]), 32'd5);
            for (int k = 0; k < 3; k++) check("lat.rise", 32'(b_rise[k] - b_acc[k]), 32'd4);
            check("lat.put_data", b_rdata[0], 32'h0);
            check("lat.get1_data", b_rdata[1], 32'h11223344);
            check("lat.get2_data", b_rdata[2], 32'h11223344);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/tlul_sram_slave.md
# tlul_sram_slave

Single-port TL-UL memory slave that sits directly downstream of `tlul_interconnect_top`. It consumes the interconnect's slave-side Channel A requests and returns Channel D responses. It supports Get, PutFullData and PutPartialData with byte-masked writes, address/size/opcode error detection and a programmable response latency. One transaction is outstanding at a time.

## Interface
- `ADDR_WIDTH`, 32: request address width.
- `DATA_WIDTH`, 32: data width; `MASK_WIDTH = DATA_WIDTH/8`.
- `SIZE_WIDTH`, 3: `a_size`/`d_size` width (log2 bytes).
- `SRC_WIDTH`, 2: source ID width.
- `SINK_WIDTH`, 1: sink ID width.
- `OPCODE_WIDTH`, 3; `PARAM_WIDTH`, 3.
- `BASE_ADDR`, 32'h0000_0000: first byte address served.
- `DEPTH`, 4096: memory words (power of two); region spans `BASE_ADDR` to `BASE_ADDR + DEPTH*MASK_WIDTH - 1`.
- `LATENCY`, 0: extra wait cycles before the response (0..15).
- `SINK_ID`, 0: constant driven on `slave_d_sink`.

Ports:
- `clk_100` in 1: the single clock. Everything is on the rising edge.
- `reset` in 1: **synchronous, active-high** reset.
- `slave_a_valid` in 1; `slave_a_ready` out 1: Channel A handshake.
- `slave_a_opcode` in OPCODE_WIDTH; `slave_a_param` in PARAM_WIDTH (ignored); `slave_a_size` in SIZE_WIDTH; `slave_a_source` in SRC_WIDTH; `slave_a_address` in ADDR_WIDTH; `slave_a_mask` in MASK_WIDTH; `slave_a_data` in DATA_WIDTH.
- `slave_d_valid` out 1; `slave_d_ready` in 1: Channel D handshake.
- `slave_d_opcode` out OPCODE_WIDTH; `slave_d_param` out PARAM_WIDTH; `slave_d_size` out SIZE_WIDTH; `slave_d_source` out SRC_WIDTH; `slave_d_sink` out SINK_WIDTH; `slave_d_data` out DATA_WIDTH; `slave_d_error` out 1.

## Operation
- **FSM states:** IDLE, WAIT, RESP.
  - `slave_a_ready = (state == IDLE)`, combinational from the state register.
- **Accept:** an accept is `slave_a_valid & slave_a_ready` at a rising edge. On accept the block captures size, source, opcode, the error flag and the read data into response registers.
  - Next state is WAIT if `LATENCY > 0` (counter loaded with `LATENCY-1`), otherwise RESP.
- **WAIT:** the counter decrements each cycle. When the counter is 0, go to RESP.
- **RESP:** `slave_d_valid = 1` and all D fields are held stable. When `slave_d_ready = 1` at an edge, go to IDLE.
- **Word index:** `(address - BASE_ADDR) >> log2(MASK_WIDTH)`, truncated to `log2(DEPTH)` bits.
- **Error** is set if any of the following holds:
  - the address is outside the region;
  - the opcode is not 0 (PutFullData), 1 (PutPartialData) or 4 (Get);
  - `a_size > log2(MASK_WIDTH)`;
  - the address is not aligned to `2^a_size`.
- **Put without error:** on the accept edge, write each byte lane whose `slave_a_mask` bit is 1. Lanes with mask bit 0 are unchanged.
- **Put with error:** no write.
- **Get without error:** the full word at the index is read on the accept edge. The value reflects all earlier completed writes.
- **Get with error:** `d_data = 0`.
- **Response fields:**
  - `d_opcode` = 1 (AccessAckData) for Get and 0 (AccessAck) for Puts and for unsupported opcodes.
  - `d_param` = 0.
  - `d_size` = captured `a_size`; `d_source` = captured `a_source`; `d_sink` = `SINK_ID`.
  - `d_data` = 0 for all non-Get responses.
- **Reset:**
  - Memory contents are not affected by reset.
  - Reset in WAIT or RESP drops the pending response: the state goes to IDLE and `d_valid` goes to 0.
  - A write already performed on accept is retained.

## Timing
- **Reset values:**
  - `slave_a_ready = 1` (IDLE).
  - `slave_d_valid = 0`.
  - `d_opcode`, `d_param`, `d_size`, `d_source`, `d_data`, `d_error` all 0.
  - `d_sink = SINK_ID`.
- **Latency:** accept at edge N gives `slave_d_valid = 1` from edge `N+1+LATENCY`.
- **Throughput:** with `d_ready` held high, minimum accept-to-accept spacing is `2+LATENCY` cycles.
- **Stalls:**
  - `slave_d_ready = 0` holds RESP indefinitely with all D fields stable.
  - `slave_a_ready` stays 0 from the accept edge until the edge after the D handshake.
- `slave_a_valid` asserted while not ready has no effect; the request must stay stable until it is accepted.
- When `LATENCY = 0` and `d_ready = 1`, the D handshake occurs on the first cycle of RESP.

## Test plan
- **Write then read:** PutFullData addr 0x2000, mask 0xF, data 0xCAFEBABE, source 1 → AccessAck (opcode 0), `d_source = 1`, `d_error = 0`. Then Get addr 0x2000, source 2 → opcode 1, `d_data = 0xCAFEBABE`, `d_size = 2`.
- **Partial write:** PutPartialData addr 0x3000, mask 0x3, data 0x12345678 over prior 0xAAAAAAAA; then Get → `d_data = 0xAAAA5678`.
- **Error cases** (each gives `d_error = 1` and no memory change):
  - Get addr 0x4000 (out of range, DEPTH 4096) → opcode 1, `d_data = 0`.
  - Opcode 2 → opcode 0.
  - Get addr 0x1002 with size 2 (misaligned) → opcode 1, `d_data = 0`.
- **Backpressure:** hold `slave_d_ready = 0` for 5 cycles after `d_valid` rises. Check that D fields stay stable, `slave_a_ready` stays 0 and a second `a_valid` is not accepted. Release → handshake, then IDLE.
- **Latency:** with `LATENCY = 3`, a Get accepted at edge N → `d_valid` rises at edge N+4. Back-to-back requests are accepted every 5 cycles.
- **Reset mid-operation:** assert `reset` while in RESP after a Put to 0x1000 (data 0xDEADBEEF) → next cycle `d_valid = 0` and `a_ready = 1`. A subsequent Get 0x1000 returns 0xDEADBEEF.
